// File: rtl/poly_eval_pkg.sv
// poly_eval_pkg: shared definitions for the polynomial evaluator.
//   - state encoding constants and the FSM state enum
//   - idx_w(): width of the load/term index counters for a given degree
package poly_eval_pkg;

  localparam logic [2:0] ST_LOAD_ENC      = 3'd0;
  localparam logic [2:0] ST_LOAD_WAIT_ENC = 3'd1;
  localparam logic [2:0] ST_MUL_ENC       = 3'd2;
  localparam logic [2:0] ST_ADD_ENC       = 3'd3;
  localparam logic [2:0] ST_DONE_ENC      = 3'd4;

  typedef enum logic [2:0] {
    LOAD      = ST_LOAD_ENC,
    LOAD_WAIT = ST_LOAD_WAIT_ENC,
    MUL       = ST_MUL_ENC,
    ADD       = ST_ADD_ENC,
    DONE      = ST_DONE_ENC
  } state_t;

  // The load index runs 0..DEGREE+1, so it needs room for DEGREE+2 values.
  function automatic int idx_w(input int degree);
    return (degree + 2 > 2) ? $clog2(degree + 2) : 1;
  endfunction

endpackage

// File: rtl/poly_eval_datapath.sv
// poly_eval_datapath: operand storage and Horner arithmetic.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load_en      write din into the slot selected by slot
//   slot         0 -> a_N, 1 -> a_N-1, ..., DEGREE -> a_0, DEGREE+1 -> x
//   start        acc <= a_N, clear overflow
//   mul_en       acc <= acc*x (wrapped)
//   add_en       acc <= acc + a_term (wrapped)
//   term         coefficient index used by add_en
//   din          load data
//   acc          running accumulator
//   ovf          sticky overflow for the current evaluation
module poly_eval_datapath
  import poly_eval_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2,
  localparam int KW    = idx_w(DEGREE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_en,
  input  logic [KW-1:0]    slot,
  input  logic             start,
  input  logic             mul_en,
  input  logic             add_en,
  input  logic [KW-1:0]    term,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] acc,
  output logic             ovf
);

  localparam logic [KW-1:0] SLOT_X = KW'(DEGREE + 1);

  // coef[j] holds the coefficient of x^j.
  logic [WIDTH-1:0] coef [DEGREE+1];
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] coef_sel;
  logic [WIDTH:0]   prod;
  logic [WIDTH:0]   sum;

  // Returns {overflow, low WIDTH bits} of the full 2*WIDTH product.
  function automatic logic [WIDTH:0] mul_wrap(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] full;
    full = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    return {|full[2*WIDTH-1:WIDTH], full[WIDTH-1:0]};
  endfunction

  // Returns the WIDTH+1 bit sum; the top bit is the carry out.
  function automatic logic [WIDTH:0] add_wrap(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  always_comb begin
    coef_sel = '0;
    for (int j = 0; j <= DEGREE; j++) begin
      if (term == KW'(j)) coef_sel = coef[j];
    end
  end

  assign prod = mul_wrap(acc, x);
  assign sum  = add_wrap(acc, coef_sel);

  // Operand storage: loaded highest coefficient first, then x.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= DEGREE; j++) coef[j] <= '0;
      x <= '0;
    end else if (load_en) begin
      if (slot == SLOT_X) x <= din;
      for (int j = 0; j <= DEGREE; j++) begin
        if (slot == KW'(DEGREE - j)) coef[j] <= din;
      end
    end
  end

  // Accumulator stage: one Horner operation per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (start) begin
      acc <= coef[DEGREE];
      ovf <= 1'b0;
    end else if (mul_en) begin
      acc <= prod[WIDTH-1:0];
      ovf <= ovf | prod[WIDTH];
    end else if (add_en) begin
      acc <= sum[WIDTH-1:0];
      ovf <= ovf | sum[WIDTH];
    end
  end

endmodule

// File: rtl/poly_eval.sv
// poly_eval: evaluates a_N*x^N + ... + a_1*x + a_0 mod 2^WIDTH by Horner's rule.
// Operands are loaded one per Go pulse: a_N, a_N-1, ..., a_0, then x.
// Ports:
//   Clock        rising-edge clock
//   Reset        asynchronous active-low reset
//   Go           load strobe (level sampled)
//   DataIn       coefficient or x value while Go is high
//   DataResult   registered result of the last completed evaluation
//   ResultValid  DataResult holds a completed evaluation
//   Busy         evaluation in progress, Go ignored
//   Overflow     sticky: an intermediate exceeded WIDTH bits
module poly_eval
  import poly_eval_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEGREE = 2
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Go,
  input  logic [WIDTH-1:0] DataIn,
  output logic [WIDTH-1:0] DataResult,
  output logic             ResultValid,
  output logic             Busy,
  output logic             Overflow
);

  localparam int            KW    = idx_w(DEGREE);
  localparam logic [KW-1:0] K_X   = KW'(DEGREE + 1);
  localparam logic [KW-1:0] I_TOP = KW'(DEGREE - 1);

  state_t           state;
  logic [KW-1:0]    k;
  logic [KW-1:0]    i;
  logic [WIDTH-1:0] acc;
  logic             load_en;
  logic             start;
  logic             mul_en;
  logic             add_en;

  assign load_en = (state == LOAD) && Go;
  assign start   = (state == LOAD_WAIT) && !Go && (k == K_X);
  assign mul_en  = (state == MUL);
  assign add_en  = (state == ADD);

  poly_eval_datapath #(
    .WIDTH  (WIDTH),
    .DEGREE (DEGREE)
  ) u_datapath (
    .clk     (Clock),
    .rst_n   (Reset),
    .load_en (load_en),
    .slot    (k),
    .start   (start),
    .mul_en  (mul_en),
    .add_en  (add_en),
    .term    (i),
    .din     (DataIn),
    .acc     (acc),
    .ovf     (Overflow)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= LOAD;
      k           <= '0;
      i           <= '0;
      DataResult  <= '0;
      ResultValid <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (Go) begin
            // The first load of a new operand set retires the old result flag.
            if (k == '0) ResultValid <= 1'b0;
            state <= LOAD_WAIT;
          end
        end
        LOAD_WAIT: begin
          if (!Go) begin
            if (k == K_X) begin
              state <= MUL;
              k     <= '0;
              i     <= I_TOP;
              Busy  <= 1'b1;
            end else begin
              k     <= k + 1'b1;
              state <= LOAD;
            end
          end
        end
        MUL: state <= ADD;
        ADD: begin
          if (i == '0) begin
            state <= DONE;
          end else begin
            i     <= i - 1'b1;
            state <= MUL;
          end
        end
        DONE: begin
          DataResult  <= acc;
          ResultValid <= 1'b1;
          Busy        <= 1'b0;
          k           <= '0;
          state       <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_eval.sv
// tb_poly_eval: randomized bench for poly_eval with a behavioural model.
module tb_poly_eval;

  localparam int D0  = 2;
  localparam int BIG = 1 << 30;

  logic        clk;
  logic        rst_n;
  logic        go0, go1;
  logic [7:0]  din0, res0;
  logic [15:0] din1, res1;
  logic        valid0, busy0, ovf0;
  logic        valid1, busy1, ovf1;

  poly_eval #(.WIDTH(8), .DEGREE(2)) dut0 (
    .Clock(clk), .Reset(rst_n), .Go(go0), .DataIn(din0),
    .DataResult(res0), .ResultValid(valid0), .Busy(busy0), .Overflow(ovf0)
  );

  poly_eval #(.WIDTH(16), .DEGREE(3)) dut1 (
    .Clock(clk), .Reset(rst_n), .Go(go1), .DataIn(din1),
    .DataResult(res1), .ResultValid(valid1), .Busy(busy1), .Overflow(ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Expected-behaviour bookkeeping for dut0, in edge numbers.
  int          t0, v_on, v_off, cap_edge;
  logic [63:0] prev_res, pend_res;
  bit          prev_ovf, pend_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Result as a plain polynomial sum mod 2^w; overflow from the Horner
  // intermediates measured at full precision.
  function automatic void eval_model(input int w, input int d, input longint unsigned a[4],
                                     input longint unsigned x,
                                     output longint unsigned res, output bit ovf);
    longint unsigned m, p, pw, acc;
    m  = 64'd1 << w;
    res = 0;
    pw  = 1;
    for (int j = 0; j <= d; j++) begin
      res = (res + (a[j] * pw) % m) % m;
      pw  = (pw * x) % m;
    end
    ovf = 0;
    acc = a[d];
    for (int j = d - 1; j >= 0; j--) begin
      p = acc * x;
      if (p >= m) ovf = 1;
      acc = p % m;
      p = acc + a[j];
      if (p >= m) ovf = 1;
      acc = p % m;
    end
  endfunction

  task automatic model_reset();
    prev_res = 0; pend_res = 0; prev_ovf = 0; pend_ovf = 0;
    t0 = -100; v_on = BIG; v_off = BIG; cap_edge = 0;
  endtask

  // Per-cycle compare of dut0 against the expectations.
  initial begin
    bit b_exp, v_exp;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      b_exp = (cyc >= t0) && (cyc <= t0 + 2 * D0);
      v_exp = (cyc >= v_on) && (cyc < v_off);
      check("busy", {63'd0, busy0}, {63'd0, b_exp});
      check("valid", {63'd0, valid0}, {63'd0, v_exp});
      check("result", {56'd0, res0}, (cyc >= v_on) ? pend_res : prev_res);
      if (!b_exp) check("overflow", {63'd0, ovf0}, {63'd0, ((cyc < t0) ? prev_ovf : pend_ovf)});
    end
  end

  // Loads a_2, a_1, a_0, x into dut0 with random Go hold/gap lengths.
  task automatic load0(input int unsigned c2, input int unsigned c1, input int unsigned c0,
                       input int unsigned xv, input bit held);
    int unsigned          v[4];
    longint unsigned      a[4];
    longint unsigned      r;
    bit                   o;
    v[0] = c2; v[1] = c1; v[2] = c0; v[3] = xv;
    for (int j = 0; j < 4; j++) begin
      if (j == 0 && held) begin
        while (cyc < cap_edge) @(negedge clk);
      end else begin
        @(negedge clk);
        go0  = 1'b1;
        din0 = 8'(v[j]);
        if (j == 0) v_off = cyc + 1;
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      go0  = 1'b0;
      din0 = 8'($urandom);
      if (j == 3) begin
        a[0] = c0; a[1] = c1; a[2] = c2; a[3] = 0;
        eval_model(8, D0, a, xv, r, o);
        prev_res = pend_res; prev_ovf = pend_ovf;
        pend_res = r;        pend_ovf = o;
        t0    = cyc + 1;
        v_on  = t0 + 2 * D0 + 1;
        v_off = BIG;
      end else begin
        repeat ($urandom_range(0, 1)) @(negedge clk);
      end
    end
  endtask

  // Rides out the computation; Go toggles randomly while busy, or, with
  // hold set, stays high carrying the next a_N into the following load.
  task automatic finish0(input bit hold, input int unsigned nxt);
    if (hold) begin
      @(negedge clk);
      go0      = 1'b1;
      din0     = 8'(nxt);
      v_off    = t0 + 2 * D0 + 2;
      cap_edge = v_off;
    end else begin
      @(negedge clk);
      while (cyc + 1 <= t0 + 2 * D0 + 1) begin
        go0  = 1'($urandom);
        din0 = 8'($urandom);
        @(negedge clk);
      end
      go0 = 1'b0;
      while (cyc < v_on) @(negedge clk);
    end
  endtask

  initial begin
    longint unsigned a[4];
    longint unsigned r;
    bit              o, held, h;
    int unsigned     nxt, c2;
    int              n;
    int unsigned     v1[5];

    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    longint unsigned a[4];
    longint unsigned r;
    bit              o, held, h;
    int unsigned     nxt, c2;
    int              n;
    int unsigned     v1[5];

    rst_n = 1'b0; go0 = 1'b0; din0 = '0; go1 = 1'b0; din1 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_result", {56'd0, res0}, 64'd0);
    check("rst_valid", {63'd0, valid0}, 64'd0);
    check("rst_busy", {63'd0, busy0}, 64'd0);
    check("rst_ovf", {63'd0, ovf0}, 64'd0);
    rst_n = 1'b1;

    // Pin the model with hand-computed values.
    a[0] = 4; a[1] = 3; a[2] = 2; a[3] = 0;
    eval_model(8, 2, a, 5, r, o);
    check("model_69", r, 64'd69);
    check("model_69_ovf", {63'd0, o}, 64'd0);
    a[0] = 0; a[1] = 0; a[2] = 16; a[3] = 0;
    eval_model(8, 2, a, 5, r, o);
    check("model_144", r, 64'd144);
    check("model_144_ovf", {63'd0, o}, 64'd1);
    a[0] = 0; a[1] = 0; a[2] = 0; a[3] = 1;
    eval_model(16, 3, a, 10, r, o);
    check("model_1000", r, 64'd1000);

    // 2x^2+3x+4 at x=5
    load0(2, 3, 4, 5, 0);
    finish0(0, 0);
    check("dut_69", {56'd0, res0}, 64'd69);
    check("dut_69_valid", {63'd0, valid0}, 64'd1);
    check("dut_69_ovf", {63'd0, ovf0}, 64'd0);

    // 16x^2 at x=5 wraps
    load0(16, 0, 0, 5, 0);
    finish0(0, 0);
    check("dut_144", {56'd0, res0}, 64'd144);
    check("dut_144_ovf", {63'd0, ovf0}, 64'd1);

    // Go held high through the computation, then back-to-back load
    load0(2, 3, 4, 5, 0);
    nxt = $urandom_range(0, 255);
    finish0(1, nxt);
    while (cyc < v_on) @(negedge clk);
    check("held_69", {56'd0, res0}, 64'd69);
    check("held_69_valid", {63'd0, valid0}, 64'd1);
    load0(nxt, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1);
    finish0(0, 0);

    // Reset during the second MUL aborts the evaluation
    load0($urandom_range(1, 255), $urandom_range(0, 255), $urandom_range(0, 255),
          $urandom_range(2, 255), 0);
    while (cyc < t0 + 2) @(negedge clk);
    rst_n = 1'b0;
    go0   = 1'b0;
    model_reset();
    #1;
    check("abort_result", {56'd0, res0}, 64'd0);
    check("abort_valid", {63'd0, valid0}, 64'd0);
    check("abort_busy", {63'd0, busy0}, 64'd0);
    check("abort_ovf", {63'd0, ovf0}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    load0(1, 1, 1, 2, 0);
    finish0(0, 0);
    check("dut_7", {56'd0, res0}, 64'd7);

    // Random evaluations, some with Go held into the next load
    held = 0;
    nxt  = 0;
    for (int k = 0; k < 25; k++) begin
      c2 = held ? nxt : $urandom_range(0, 255);
      load0(c2, $urandom_range(0, 255), $urandom_range(0, 255),
            ($urandom_range(0, 1) == 1) ? $urandom_range(0, 3) : $urandom_range(0, 255), held);
      h   = ($urandom_range(0, 3) == 0);
      nxt = $urandom_range(0, 255);
      finish0(h, nxt);
      held = h;
    end
    if (held) begin
      load0(nxt, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1);
      finish0(0, 0);
    end

    // WIDTH=16, DEGREE=3: x^3 at x=10, 7-edge latency
    v1[0] = 1; v1[1] = 0; v1[2] = 0; v1[3] = 0; v1[4] = 10;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      go1  = 1'b1;
      din1 = 16'(v1[j]);
      @(negedge clk);
      go1 = 1'b0;
    end
    @(posedge clk);
    n = 0;
    while (valid1 !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("w16_latency", 64'(n), 64'd7);
    check("w16_result", {48'd0, res1}, 64'd1000);
    check("w16_ovf", {63'd0, ovf1}, 64'd0);
    check("w16_busy", {63'd0, busy1}, 64'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
